// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: rotates a one-hot column drive, samples the synchronized rows
// once per dwell, and debounces press and release before handing {rows, cols} to the encoder.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state;
  logic [3:0]      sync1, rs;
  logic [3:0]      cand_row, cand_col;
  logic [DW-1:0]   div;
  logic [CW-1:0]   cnt;
  logic            sample, onehot;
  logic [3:0]      rotated;

  assign sample  = (div == DIV_LAST);
  assign onehot  = (rs != 4'd0) && ((rs & (rs - 4'd1)) == 4'd0);
  assign rotated = {col_drive[2:0], col_drive[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      sync1     <= '0;
      rs        <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      div       <= '0;
      cnt       <= '0;
      col_drive <= 4'b0001;
      rows      <= '0;
      cols      <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= row_in;
      rs        <= sync1;
      key_valid <= 1'b0;
      div       <= sample ? '0 : div + DW'(1);
      if (sample) begin
        case (state)
          SCAN: begin
            if (onehot) begin
              cand_row <= rs;
              cand_col <= col_drive;
              cnt      <= CW'(1);
              state    <= DEBOUNCE;
            end else begin
              col_drive <= rotated;
            end
          end
          DEBOUNCE: begin
            if (rs == cand_row) begin
              if (cnt >= CNT_PRE) begin
                rows      <= cand_row;
                cols      <= cand_col;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= CNT_MAX;
                state     <= HELD;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              // bounce, release or a second key: abandon the candidate
              cnt       <= '0;
              state     <= SCAN;
              col_drive <= rotated;
            end
          end
          HELD: begin
            if (rs == 4'd0) begin
              cnt   <= CW'(1);
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (rs == 4'd0) begin
              if (cnt >= CNT_PRE) begin
                key_held  <= 1'b0;
                cnt       <= '0;
                state     <= SCAN;
                col_drive <= rotated;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              cnt   <= '0;
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives row_in from col_drive,
// expected key reports are queued at press time and popped on each key_valid.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_drive, rows, cols;
  logic       key_valid, key_held;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_drive(col_drive),
    .rows(rows), .cols(cols), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [3:0] key_row = 4'd0, key_col = 4'd0;
  logic       key_on = 1'b0, glitch = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // keypad: the pressed key's row reads high only while its column is driven
  task automatic upd_row();
    row_in = (key_on && !glitch && col_drive == key_col) ? key_row : 4'd0;
  endtask

  // one clock; scoreboard pops on every key_valid
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    @(negedge clk);
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", {31'd0, key_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("key_report", {23'd0, rows, cols, key_held}, {23'd0, e, 1'b1});
      end
    end
    upd_row();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c);
    key_row = r; key_col = c; key_on = 1'b1; upd_row();
  endtask

  task automatic wait_held(input string tag, input logic v, input int max, output int n);
    n = 0;
    while (key_held !== v && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'd0, key_held}, {31'd0, v});
  endtask

  // stops at the negedge right after col_drive rotates onto c
  task automatic wait_col(input string tag, input logic [3:0] c);
    logic [3:0] prev;
    int n;
    prev = col_drive;
    n = 0;
    while (!(prev != c && col_drive == c) && n < 64) begin
      prev = col_drive;
      step();
      n++;
    end
    chk(tag, {28'd0, col_drive}, {28'd0, c});
  endtask

  initial begin
    int n, trans;
    logic [3:0] pc;
    rst = 1'b1; row_in = 4'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_col", {28'd0, col_drive}, 32'h1);
    chk("rst_rows", {28'd0, rows}, 32'h0);
    chk("rst_cols", {28'd0, cols}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_held", {31'd0, key_held}, 32'h0);
    rst = 1'b0;

    // 1: idle rotation, one column per 4 clocks
    for (int k = 1; k <= 64; k++) begin
      step();
      chk("idle_col", {28'd0, col_drive}, 32'(1 << ((k / 4) % 4)));
    end
    chk("idle_rowscols", {24'd0, rows, cols}, 32'h0);

    // 2: key '8', stable press then release
    press(4'b0100, 4'b0010);
    exp_q.push_back(8'b0100_0010);
    wait_held("k8_held", 1'b1, 100, n);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("k8_frozen", {27'd0, key_held, col_drive}, {27'd0, 1'b1, 4'b0010});
    end
    key_on = 1'b0; upd_row();
    wait_held("k8_released", 1'b0, 40, n);
    chk("k8_release_lat", {31'd0, (n >= 11 && n <= 14)}, 32'd1);
    chk("k8_resume_col", {28'd0, col_drive}, 32'h4);
    chk("k8_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: key '5' with one bounced dwell after the first sample
    press(4'b0010, 4'b0010);
    wait_col("k5_reach_col", 4'b0010);
    steps(4);
    glitch = 1'b1; upd_row();
    steps(4);
    glitch = 1'b0; upd_row();
    chk("k5_bounce_rotate", {28'd0, col_drive}, 32'h4);
    chk("k5_bounce_held", {31'd0, key_held}, 32'h0);
    exp_q.push_back(8'b0010_0010);
    wait_held("k5_held", 1'b1, 100, n);
    key_on = 1'b0; upd_row();
    wait_held("k5_released", 1'b0, 40, n);

    // 4: two rows in one column is ignored
    press(4'b0011, 4'b0001);
    trans = 0;
    for (int i = 0; i < 40; i++) begin
      pc = col_drive;
      step();
      if (col_drive != pc) trans++;
    end
    chk("multi_rotations", 32'(trans), 32'd10);
    chk("multi_held", {31'd0, key_held}, 32'h0);
    chk("multi_rowscols", {24'd0, rows, cols}, 32'h22);
    key_on = 1'b0; upd_row();

    // 5: key 'D' held long with a two-dwell release glitch
    press(4'b1000, 4'b1000);
    exp_q.push_back(8'b1000_1000);
    wait_held("kd_held", 1'b1, 100, n);
    steps(40);
    glitch = 1'b1; upd_row();
    steps(8);
    glitch = 1'b0; upd_row();
    steps(12);
    chk("kd_glitch_held", {31'd0, key_held}, 32'h1);
    steps(28);
    key_on = 1'b0; upd_row();
    wait_held("kd_released", 1'b0, 40, n);
    chk("kd_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset while debouncing key '8'
    press(4'b0100, 4'b0010);
    wait_col("rst_reach_col", 4'b0010);
    steps(4);
    chk("deb_frozen", {28'd0, col_drive}, 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_col", {28'd0, col_drive}, 32'h1);
    chk("mid_rst_held", {31'd0, key_held}, 32'h0);
    chk("mid_rst_valid", {31'd0, key_valid}, 32'h0);
    chk("mid_rst_rowscols", {24'd0, rows, cols}, 32'h0);
    exp_q.push_back(8'b0100_0010);
    wait_held("post_rst_held", 1'b1, 100, n);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
